// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// master drives operands and out_ready; slave is the adder.
interface seq_chunk_adder_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry held in a register.
// Operands shift right each cycle so the slice always reads the low chunk.
module seq_chunk_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_chunk_adder_if.slave bus
);
   localparam int unsigned NCH  = WIDTH / CHUNK;
   localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_out_valid;
   logic             r_in_ready;

   logic [CHUNK:0]   w_chunk_sum;
   logic [WIDTH-1:0] w_work_nxt;
   logic             w_ovf;
   logic             w_last;
   logic             w_accept;
   logic             w_step;
   logic             w_finish;

   // Slice adder on the low chunk; the finished chunk enters the working result from the top
   assign w_chunk_sum = (CHUNK+1)'(r_a[CHUNK-1:0]) + (CHUNK+1)'(r_b[CHUNK-1:0])
                      + (CHUNK+1)'(r_carry);
   assign w_work_nxt  = WIDTH'({w_chunk_sum[CHUNK-1:0], r_work} >> CHUNK);
   assign w_last      = (r_idx == LAST_IDX);
   // On the last chunk the low slice of the operand registers holds the original MSBs
   assign w_ovf       = (r_a[CHUNK-1] == r_b[CHUNK-1]) & (w_chunk_sum[CHUNK-1] != r_a[CHUNK-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last)        w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         S_IDLE:  w_accept = bus.in_valid;
         S_RUN: begin
            w_step   = 1'b1;
            w_finish = w_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_work      <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_idx   <= '0;
            r_work  <= '0;
         end else if (w_step) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_chunk_sum[CHUNK];
            r_idx   <= r_idx + IDXW'(1);
            r_work  <= w_work_nxt;
         end
         if (w_finish) begin
            r_sum  <= w_work_nxt;
            r_cout <= w_chunk_sum[CHUNK];
            r_ovf  <= w_ovf;
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: 4-chunk instance plus a single-chunk instance,
// expected results queued at accept and compared when each result is handed off.
module tb_seq_chunk_adder;
   localparam int unsigned W = 32;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_chunk_adder_if #(.WIDTH(W)) bus0 ();
   seq_chunk_adder_if #(.WIDTH(W)) bus1 ();

   seq_chunk_adder #(.WIDTH(W), .CHUNK(8))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   seq_chunk_adder #(.WIDTH(W), .CHUNK(32)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   res_t sb0[$];
   res_t sb1[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc0 = 0;
   int   acc1 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W:0]   t;
      logic [W-1:0] bb;
      res_t         r;
      bb     = sub ? ~b : b;
      t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
      return r;
   endfunction

   // Present operands from a negedge until accepted; queue the model's answer.
   task automatic send(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, output bit ok);
      ok = 1'b0;
      if (sel) begin
         bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub; bus1.in_valid = 1'b1;
      end else begin
         bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub; bus0.in_valid = 1'b1;
      end
      for (int i = 0; i < 64 && !ok; i++) begin
         if ((sel ? bus1.in_ready : bus0.in_ready) === 1'b1) begin
            ok = 1'b1;
            if (sel) begin acc1 = cyc + 1; sb1.push_back(model(a, b, cin, sub)); end
            else     begin acc0 = cyc + 1; sb0.push_back(model(a, b, cin, sub)); end
         end
         @(negedge clk);
      end
      if (sel) bus1.in_valid = 1'b0;
      else     bus0.in_valid = 1'b0;
   endtask

   // Wait for a result, capture it and its latency, and take it with out_ready.
   task automatic collect(input bit sel, output res_t got, output int lat, output bit ok);
      ok = 1'b0; got = '0; lat = -1;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (sel && bus1.out_valid === 1'b1) begin
            got = {bus1.sum, bus1.cout, bus1.ovf}; lat = cyc - acc1; ok = 1'b1;
            bus1.out_ready = 1'b1;
         end else if (!sel && bus0.out_valid === 1'b1) begin
            got = {bus0.sum, bus0.cout, bus0.ovf}; lat = cyc - acc0; ok = 1'b1;
            bus0.out_ready = 1'b1;
         end
         @(negedge clk);
      end
      if (sel) bus1.out_ready = 1'b0;
      else     bus0.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [W+3:0] want;
      want = {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0};
      n_cmp++;
      if ({bus0.in_ready, bus0.out_valid, bus0.sum, bus0.cout, bus0.ovf} !== want) begin
         n_fail++;
         $display("FAIL reset_dut4: got rdy=%b vld=%b sum=%h, want rdy=1 vld=0 sum=0",
                  bus0.in_ready, bus0.out_valid, bus0.sum);
      end
      n_cmp++;
      if ({bus1.in_ready, bus1.out_valid, bus1.sum, bus1.cout, bus1.ovf} !== want) begin
         n_fail++;
         $display("FAIL reset_dut1: got rdy=%b vld=%b sum=%h, want rdy=1 vld=0 sum=0",
                  bus1.in_ready, bus1.out_valid, bus1.sum);
      end
   endtask

   // Table-driven ops on either instance, checking result and latency.
   task automatic run_table(input string name, input bit sel, input int exp_lat,
                            input logic [W-1:0] ta[], input logic [W-1:0] tb[],
                            input logic tc[], input logic ts[]);
      bit   sok, cok;
      res_t got, exp;
      int   lat;
      foreach (ta[k]) begin
         send(sel, ta[k], tb[k], tc[k], ts[k], sok);
         n_cmp++;
         if (!sok) begin
            n_fail++;
            $display("FAIL %s_accept[%0d]: got no accept, want accept", name, k);
            continue;
         end
         collect(sel, got, lat, cok);
         exp = sel ? sb1.pop_front() : sb0.pop_front();
         n_cmp++;
         if (!cok || got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, k, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
         end
         n_cmp++;
         if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency[%0d]: got %0d, want %0d", name, k, lat, exp_lat);
         end
      end
   endtask

   task automatic test_carry_and_overflow();
      logic [W-1:0] ta[] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
      logic [W-1:0] tb[] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
      logic         tc[] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic         ts[] = '{1'b0, 1'b0, 1'b1, 1'b1};
      run_table("carry_ovf", 1'b0, 4, ta, tb, tc, ts);
   endtask

   task automatic test_single_chunk();
      logic [W-1:0] ta[] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [W-1:0] tb[] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
      logic         tc[] = '{1'b1, 1'b0, 1'b0};
      logic         ts[] = '{1'b0, 1'b0, 1'b1};
      run_table("single_chunk", 1'b1, 1, ta, tb, tc, ts);
   endtask

   // Input changes and an early out_ready during RUN must not disturb the result.
   task automatic test_run_isolation();
      bit   sok, cok;
      res_t got, exp;
      int   lat;
      send(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, sok);
      bus0.a = '1; bus0.b = '1; bus0.sub = 1'b1; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      collect(1'b0, got, lat, cok);
      n_cmp++;
      if (!sok || !cok || sb0.size() != 1) begin
         n_fail++;
         $display("FAIL isolation_handshake: got accept=%b result=%b queued=%0d, want 1 1 1",
                  sok, cok, sb0.size());
         sb0.delete();
         return;
      end
      exp = sb0.pop_front();
      n_cmp++;
      if (got !== exp || lat != 4) begin
         n_fail++;
         $display("FAIL isolation: got sum=%h lat=%0d, want sum=%h lat=4", got.sum, lat, exp.sum);
      end
      n_cmp++;
      if ({bus0.out_valid, bus0.in_ready, bus0.sum} !== {1'b0, 1'b1, exp.sum}) begin
         n_fail++;
         $display("FAIL after_handoff: got vld=%b rdy=%b sum=%h, want vld=0 rdy=1 sum=%h",
                  bus0.out_valid, bus0.in_ready, bus0.sum, exp.sum);
      end
   endtask

   task automatic test_backpressure();
      bit   sok, cok, seen;
      res_t got, exp_a, exp_b;
      int   lat;
      send(1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, sok);
      seen = 1'b0;
      for (int i = 0; i < 32 && !seen; i++) begin
         if (bus0.out_valid === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!sok || !seen) begin
         n_fail++;
         $display("FAIL bp_first_result: got accept=%b valid=%b, want 1 1", sok, seen);
         return;
      end
      exp_a = sb0.pop_front();
      bus0.a = 32'h0000_0010; bus0.b = 32'h0000_0003; bus0.cin = 1'b0; bus0.sub = 1'b1;
      bus0.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({bus0.out_valid, bus0.in_ready, bus0.sum, bus0.cout, bus0.ovf} !==
             {1'b1, 1'b0, exp_a}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h, want vld=1 rdy=0 sum=%h",
                     i, bus0.out_valid, bus0.in_ready, bus0.sum, exp_a.sum);
         end
         @(negedge clk);
      end
      bus0.out_ready = 1'b1;
      @(negedge clk);
      bus0.out_ready = 1'b0;
      n_cmp++;
      if ({bus0.out_valid, bus0.in_ready, bus0.sum} !== {1'b0, 1'b1, exp_a.sum}) begin
         n_fail++;
         $display("FAIL bp_handoff: got vld=%b rdy=%b sum=%h, want vld=0 rdy=1 sum=%h",
                  bus0.out_valid, bus0.in_ready, bus0.sum, exp_a.sum);
      end
      acc0 = cyc + 1;
      exp_b = model(32'h0000_0010, 32'h0000_0003, 1'b0, 1'b1);
      sb0.push_back(exp_b);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      n_cmp++;
      if (bus0.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accept: got in_ready=%b, want 0", bus0.in_ready);
      end
      collect(1'b0, got, lat, cok);
      exp_b = sb0.pop_front();
      n_cmp++;
      if (!cok || got !== exp_b || lat != 4) begin
         n_fail++;
         $display("FAIL bp_second: got sum=%h lat=%0d, want sum=%h lat=4", got.sum, lat, exp_b.sum);
      end
   endtask

   task automatic test_reset_mid();
      bit   sok, cok;
      res_t got, exp;
      int   lat;
      logic [W-1:0] ta[] = '{32'h0000_0003};
      logic [W-1:0] tb[] = '{32'h0000_0004};
      logic         tc[] = '{1'b0};
      logic         ts[] = '{1'b0};
      send(1'b0, 32'hAAAA_5555, 32'h1234_5678, 1'b0, 1'b0, sok);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus0.in_ready, bus0.out_valid, bus0.sum, bus0.cout, bus0.ovf} !==
          {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset: got rdy=%b vld=%b sum=%h, want rdy=1 vld=0 sum=0",
                  bus0.in_ready, bus0.out_valid, bus0.sum);
      end
      sb0.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_table("after_reset", 1'b0, 4, ta, tb, tc, ts);
      exp = model(32'h3, 32'h4, 1'b0, 1'b0);
      n_cmp++;
      if (exp.sum !== bus0.sum || bus0.sum !== 32'h0000_0007) begin
         n_fail++;
         $display("FAIL after_reset_sum: got %h, want 00000007", bus0.sum);
      end
      got = '0; lat = 0; cok = sok;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ta[];
      logic [W-1:0] tb[];
      logic         tc[];
      logic         ts[];
      ta = new[8]; tb = new[8]; tc = new[8]; ts = new[8];
      foreach (ta[k]) begin
         ta[k] = $urandom; tb[k] = $urandom;
         tc[k] = 1'($urandom_range(0, 1)); ts[k] = 1'($urandom_range(0, 1));
      end
      run_table("random", 1'b0, 4, ta, tb, tc, ts);
   endtask

   initial begin
      bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
      bus0.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
      bus1.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_carry_and_overflow();
      test_run_isolation();
      test_backpressure();
      test_reset_mid();
      test_single_chunk();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
